// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers for the
// key schedule and the round datapath.
package aes_pkg;

  localparam int AES_NK     = 4;
  localparam int AES_NR     = 10;
  localparam int AES_RK_CNT = 11;

  typedef enum logic [1:0] {IDLE, SUB, MIX} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared with the round datapath.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule with one shared S-box and an 11-entry round-key file.
// Optional macro AES_KEY_REUSE_EN skips re-expansion when the same key is loaded again.
//
// state | meaning
// IDLE  | waiting for start; round-key file readable
// SUB   | one RotWord byte per cycle through the S-box into tmp
// MIX   | fold tmp into the previous round key, write rk[round]
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         valid
);

  state_e       state_q, state_d;
  logic [127:0] rk_q [AES_RK_CNT];
  logic [127:0] rk_d [AES_RK_CNT];
  logic [7:0]   tmp_q [4];
  logic [7:0]   tmp_d [4];
  logic [3:0]   round_q, round_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
`ifdef AES_KEY_REUSE_EN
  logic [127:0] last_key_q, last_key_d;
`endif

  logic [127:0] prev_rk;
  logic [31:0]  t, w0n, w1n, w2n, w3n;
  logic [7:0]   sbox_in, sbox_out;
  logic         skip;

  assign prev_rk = rk_q[round_q - 4'd1];

  // RotWord: byte_cnt k picks byte (k+1) mod 4 of the last word, byte 0 being the MSB
  always_comb begin
    case (byte_cnt_q)
      2'd0:    sbox_in = prev_rk[23:16];
      2'd1:    sbox_in = prev_rk[15:8];
      2'd2:    sbox_in = prev_rk[7:0];
      default: sbox_in = prev_rk[31:24];
    endcase
  end

  aes_sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  assign t   = {tmp_q[0], tmp_q[1], tmp_q[2], tmp_q[3]} ^ {rcon_q, 24'h0};
  assign w0n = prev_rk[127:96] ^ t;
  assign w1n = prev_rk[95:64]  ^ w0n;
  assign w2n = prev_rk[63:32]  ^ w1n;
  assign w3n = prev_rk[31:0]   ^ w2n;

  always_comb begin
    state_d    = state_q;
    rk_d       = rk_q;
    tmp_d      = tmp_q;
    round_d    = round_q;
    byte_cnt_d = byte_cnt_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    skip       = 1'b0;
`ifdef AES_KEY_REUSE_EN
    last_key_d = last_key_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef AES_KEY_REUSE_EN
          skip       = valid_q && (key_in == last_key_q);
          last_key_d = key_in;
`endif
          if (skip) begin
            done_d = 1'b1;
          end else begin
            rk_d[0]    = key_in;
            round_d    = 4'd1;
            byte_cnt_d = 2'd0;
            rcon_d     = 8'h01;
            busy_d     = 1'b1;
            valid_d    = 1'b0;
            state_d    = SUB;
          end
        end
      end
      SUB: begin
        tmp_d[byte_cnt_q] = sbox_out;
        byte_cnt_d        = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) state_d = MIX;
      end
      MIX: begin
        rk_d[round_q] = {w0n, w1n, w2n, w3n};
        rcon_d        = xtime(rcon_q);
        if (round_q == 4'(AES_NR)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          round_d    = round_q + 4'd1;
          byte_cnt_d = 2'd0;
          state_d    = SUB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < AES_RK_CNT; i++) rk_q[i] <= '0;
      for (int j = 0; j < 4; j++) tmp_q[j] <= '0;
      round_q    <= '0;
      byte_cnt_q <= '0;
      rcon_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef AES_KEY_REUSE_EN
      last_key_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      tmp_q      <= tmp_d;
      round_q    <= round_d;
      byte_cnt_q <= byte_cnt_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
`ifdef AES_KEY_REUSE_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  assign rk_out = (rk_idx <= 4'd10) ? rk_q[rk_idx] : '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, latency, ignored
// restarts, async reset mid-expansion and same-key reload (AES_KEY_REUSE_EN aware).
module tb_aes_key_expand;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk_out;
  logic         busy, done, valid;

  aes_key_expand dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .key_in (key_in),
    .rk_idx (rk_idx),
    .rk_out (rk_out),
    .busy   (busy),
    .done   (done),
    .valid  (valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
    int           edges;
    int           busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;

  localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO    = 128'h0;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    rk_idx = idx;
    #1;
    val = rk_out;
  endtask

  // Drives start at a negedge, waits for done; optionally pulses a second start
  // (with a different key) at cycle intr_cyc to prove it is ignored.
  task automatic run_key(input logic [127:0] key, input logic [127:0] rk1,
                         input logic [127:0] rk10, input int edges, input int bcyc,
                         input int intr_cyc);
    exp_t e;
    exp_t got_e;
    int cnt, busy_n;
    bit got;
    logic [127:0] v;
    e.key = key; e.rk1 = rk1; e.rk10 = rk10; e.edges = edges; e.busy_cycles = bcyc;
    exp_q.push_back(e);
    start  = 1'b1;
    key_in = key;
    @(negedge clock);
    cnt = 1; busy_n = 0; got = 0;
    while (cnt <= 200 && !got) begin
      if (busy) busy_n++;
      if (done) begin
        got = 1;
      end else begin
        if (cnt == intr_cyc) begin
          start  = 1'b1;
          key_in = ~key;
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
        cnt++;
      end
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 128'd0, 128'd1);
      void'(exp_q.pop_front());
    end else begin
      got_e = exp_q.pop_front();
      chk("done_latency", 128'(cnt - 1), 128'(got_e.edges));
      chk("busy_cycles", 128'(busy_n), 128'(got_e.busy_cycles));
      chk("valid_at_done", 128'(valid), 128'd1);
      read_rk(4'd0, v);  chk("rk0", v, got_e.key);
      read_rk(4'd1, v);  chk("rk1", v, got_e.rk1);
      read_rk(4'd10, v); chk("rk10", v, got_e.rk10);
    end
  endtask

  initial begin
    logic [127:0] v;
    int cnt;

    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_valid", 128'(valid), 128'd0);
    read_rk(4'd0, v); chk("rst_rk0", v, 128'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_key(K_FIPS, FIPS_RK1, FIPS_RK10, 50, 50, -1);
    @(negedge clock);
    chk("done_one_cycle", 128'(done), 128'd0);
    chk("valid_holds", 128'(valid), 128'd1);
    read_rk(4'd11, v); chk("rk11_zero", v, 128'd0);
    read_rk(4'd15, v); chk("rk15_zero", v, 128'd0);

    // Second start at cycle 20 must neither restart nor change the key.
    run_key(K_ZERO, ZERO_RK1, ZERO_RK10, 50, 50, 20);
    // Next start lands in the done cycle and is accepted.
`ifdef AES_KEY_REUSE_EN
    run_key(K_ZERO, ZERO_RK1, ZERO_RK10, 0, 0, -1);
`else
    run_key(K_ZERO, ZERO_RK1, ZERO_RK10, 50, 50, -1);
`endif
    @(negedge clock);
    chk("done_low_after", 128'(done), 128'd0);

    // Async reset in the middle of an expansion.
    start  = 1'b1;
    key_in = K_FIPS;
    @(negedge clock);
    start = 1'b0;
    cnt   = 1;
    while (cnt < 25) begin
      @(negedge clock);
      cnt++;
    end
    chk("busy_mid_expand", 128'(busy), 128'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_valid", 128'(valid), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    for (int i = 0; i < 16; i++) begin
      read_rk(4'(i), v);
      chk($sformatf("arst_rk%0d", i), v, 128'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_key(K_FIPS, FIPS_RK1, FIPS_RK10, 50, 50, -1);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule unit producing the 11 round keys (rk0..rk10) from a 128-bit cipher key and holding them in a readable round-key file. It sits between the PCPI AES coprocessor's key register and the AES round datapath. Expansion runs once per key load, and the encryption core then indexes round keys without recomputing them. A single time-multiplexed S-box keeps area small, at the cost of a 50-cycle expansion.

## Interface
Parameters: none. Widths are fixed by AES-128 and declared as constants in the package.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request expansion of key_in; sampled only when busy=0
- key_in  in  128  cipher key; key_in[127:120] is FIPS-197 byte 0; w0 = key_in[127:96]
- rk_idx  in  4  round-key select, 0..10
- rk_out  out  128  round key rk_idx = {w[4i], w[4i+1], w[4i+2], w[4i+3]}; combinational read; 0 for rk_idx 11..15
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the round-key file is complete
- valid  out  1  round-key file holds a complete expansion of the last accepted key

## Operation
- The state machine has three states: IDLE, SUB, MIX.
- IDLE:
  - start=1 → rk[0] <= key_in, round <= 1, byte_cnt <= 0, rcon <= 8'h01, busy <= 1, valid <= 0, go to SUB.
  - start=0 → hold.
- SUB (4 cycles):
  - Each cycle one byte of RotWord(w[4·round−1]), selected by byte_cnt 0..3, goes through the shared S-box.
  - The result is written into tmp[byte_cnt].
  - When byte_cnt=3, go to MIX.
- MIX (1 cycle):
  - t = tmp ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2', where w0..w3 come from rk[round−1].
  - rk[round] <= {w0', w1', w2', w3'}.
  - rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
  - If round=10: busy <= 0, valid <= 1, done <= 1, go to IDLE. Otherwise round++, byte_cnt <= 0, go to SUB.
- All arithmetic is GF(2^8) XOR. xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0).
- start while busy=1 is ignored; it is neither queued nor does it restart expansion.
- key_in is captured only on the accepted start edge. Later changes to key_in have no effect.
- rk_out during busy returns the current register contents. Consumers must wait for done or valid before reading.

## Timing
- Reset (asynchronous, any state, including mid-expansion): state=IDLE, busy=0, done=0, valid=0, all rk[0..10]=0, rk_out=0, round=0, byte_cnt=0, rcon=0.
- Start accepted at edge T. rk1 is written at T+5, and rk[n] at T+5n. done=1 during the cycle after edge T+50, and busy falls at the same edge.
- Expansion latency is 50 cycles. done lasts exactly one cycle.
- start asserted in the cycle where done=1 is accepted, because busy is already 0; a new expansion begins.
- rk_out has zero-cycle latency from rk_idx (pure mux).

## Configuration
- AES_KEY_REUSE_EN defined:
  - Adds a 128-bit last_key register, loaded on every accepted start.
  - start with valid=1 and key_in == last_key skips expansion: done pulses one cycle later, busy stays 0, and the rk file and valid are untouched.
  - Reset clears last_key to 0.
- AES_KEY_REUSE_EN undefined: every accepted start runs the full 50-cycle expansion.

## Structure
- Package aes_pkg:
  - AES_NK=4, AES_NR=10, AES_RK_CNT=11
  - state enum {IDLE, SUB, MIX}
  - xtime function
  - The package is shared with the encryption datapath.
- Sub-module aes_sbox: a combinational 8-bit forward S-box, the same module instantiated by the round datapath. One instance here.

## Test plan
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk1 = a0fafe1788542cb123a339392a6c7605
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - valid=1 after done
- All-zero key:
  - rk1 = 62636363626363636263636362636363
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Latency: done rises exactly 50 cycles after the accepted start edge. busy is high for 50 cycles. A second start pulse at cycle 20 is ignored (no restart, same rk10).
- Asynchronous reset asserted at cycle 25 of an expansion → busy, valid and done are 0 immediately; rk_out=0 for every rk_idx. A fresh start then completes normally.
- rk_idx = 11 and rk_idx = 15 → rk_out = 0. rk_idx = 0 → the key as loaded.
- Two starts with the same key:
  - AES_KEY_REUSE_EN defined: second done one cycle after start, busy never high.
  - AES_KEY_REUSE_EN undefined: second done after 50 cycles.
  - Both builds: identical rk10.
